// File: rtl/barreira_pkg.sv
// Shared definitions for the N-channel car-park barrier controller.
// Holds the per-channel state encoding, the operating-mode codes and the
// default plate width used by barreira_ctrl_n and barreira_canal.
package barreira_pkg;

    // Per-channel barrier state
    typedef enum logic {
        FECHADA = 1'b0,
        ABERTA  = 1'b1
    } estado_t;

    // Global operating mode; 2'b11 is treated as automatic
    localparam logic [1:0] MODO_AUTO   = 2'b00;
    localparam logic [1:0] MODO_ABRIR  = 2'b01;
    localparam logic [1:0] MODO_FECHAR = 2'b10;

    // Default plate (matricula) width in bits
    localparam int PW_DEF = 24;

endpackage

// File: rtl/barreira_canal.sv
// One barrier channel: FECHADA/ABERTA FSM, open-time cycle timer and the
// register holding the last accepted plate.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   i_aceita       request accepted this cycle (already decoded by the top)
//   i_rejeita      request rejected this cycle
//   i_plate        plate presented with the request
//   i_veiculo      1 = vehicle under the barrier
//   i_t_aberto     open time in vehicle-free cycles (0 behaves as 1)
//   i_modo         global mode (auto / force open / force closed)
//   o_barreira     1 = closed, 0 = open (registered)
//   o_aceite       1-cycle accept pulse (registered)
//   o_rejeitada    1-cycle reject pulse (registered)
//   o_matr_reg     last accepted plate
//   o_estado       current FSM state, for observation
module barreira_canal
    import barreira_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_aceita,
    input  logic          i_rejeita,
    input  logic [PW-1:0] i_plate,
    input  logic          i_veiculo,
    input  logic [CW-1:0] i_t_aberto,
    input  logic [1:0]    i_modo,
    output logic          o_barreira,
    output logic          o_aceite,
    output logic          o_rejeitada,
    output logic [PW-1:0] o_matr_reg,
    output estado_t       o_estado
);

    estado_t       r_estado;
    estado_t       w_estado_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic [CW-1:0] w_lim_m1;
    logic          r_aceite;
    logic          r_rejeitada;
    logic [PW-1:0] r_matr;

    // Last count value before closing; t_aberto=0 is treated as 1.
    assign w_lim_m1 = (i_t_aberto == '0) ? '0 : (i_t_aberto - CW'(1));

    always_comb begin
        w_estado_n = r_estado;
        w_cnt_n    = r_cnt;
        if (i_aceita) begin
            // An accepted request always (re)opens and restarts the timer,
            // even on the edge where the timer would have expired.
            w_estado_n = ABERTA;
            w_cnt_n    = '0;
        end else if (i_modo == MODO_ABRIR) begin
            w_estado_n = ABERTA;
            w_cnt_n    = '0;
        end else if (i_modo == MODO_FECHAR) begin
            w_cnt_n = '0;
            // Never lower the barrier onto a vehicle.
            if (r_estado == ABERTA && !i_veiculo) begin
                w_estado_n = FECHADA;
            end
        end else if (r_estado == ABERTA) begin
            if (i_veiculo) begin
                w_cnt_n = '0;
            end else if (r_cnt >= w_lim_m1) begin
                // '>=' so a t_aberto reduced mid-count closes right away.
                w_estado_n = FECHADA;
                w_cnt_n    = '0;
            end else begin
                w_cnt_n = r_cnt + CW'(1);
            end
        end else begin
            w_cnt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= FECHADA;
            r_cnt       <= '0;
            r_aceite    <= 1'b0;
            r_rejeitada <= 1'b0;
            r_matr      <= '0;
        end else begin
            r_estado    <= w_estado_n;
            r_cnt       <= w_cnt_n;
            r_aceite    <= i_aceita;
            r_rejeitada <= i_rejeita;
            if (i_aceita) begin
                r_matr <= i_plate;
            end
        end
    end

    assign o_barreira  = (r_estado == FECHADA);
    assign o_aceite    = r_aceite;
    assign o_rejeitada = r_rejeitada;
    assign o_matr_reg  = r_matr;
    assign o_estado    = r_estado;

endmodule

// File: rtl/barreira_ctrl_n.sv
// N-channel barrier controller top level: decodes plate requests into
// accept/reject per channel, instantiates one barreira_canal per channel and
// keeps a saturating count of accepted entries.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   matricula    plate per channel, channel i = [i*PW +: PW]
//   matr_val     plate-valid strobe per channel
//   veiculo      vehicle-present sensor per channel
//   t_aberto     open time in cycles, shared (0 behaves as 1)
//   modo         00 auto, 01 force open, 10 force closed, 11 auto
//   barreira     1 = closed per channel
//   aceite       1-cycle accept pulse per channel
//   rejeitada    1-cycle reject pulse per channel
//   matr_reg     last accepted plate per channel
//   contagem     total accepted requests, saturating
//   estado_dbg   per-channel FSM state (1 = ABERTA), for observation
module barreira_ctrl_n
    import barreira_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int PW   = PW_DEF,
    parameter int CW   = 7,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*PW-1:0] matricula,
    input  logic [NCH-1:0]    matr_val,
    input  logic [NCH-1:0]    veiculo,
    input  logic [CW-1:0]     t_aberto,
    input  logic [1:0]        modo,
    output logic [NCH-1:0]    barreira,
    output logic [NCH-1:0]    aceite,
    output logic [NCH-1:0]    rejeitada,
    output logic [NCH*PW-1:0] matr_reg,
    output logic [CNTW-1:0]   contagem,
    output logic [NCH-1:0]    estado_dbg
);

    localparam int PCW = $clog2(NCH + 1);
    localparam int SW  = CNTW + PCW;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [NCH-1:0]  w_aceita;
    logic [NCH-1:0]  w_rejeita;
    logic [PCW-1:0]  w_pop;
    logic [SW-1:0]   w_soma;
    logic [CNTW-1:0] r_cont;
    estado_t         w_estado [NCH];

    // A request is rejected for an all-zero plate or in force-closed mode.
    always_comb begin
        w_aceita  = '0;
        w_rejeita = '0;
        for (int i = 0; i < NCH; i++) begin
            if (matr_val[i]) begin
                if (matricula[i*PW +: PW] != '0 && modo != MODO_FECHAR) begin
                    w_aceita[i] = 1'b1;
                end else begin
                    w_rejeita[i] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_canal
        barreira_canal #(
            .PW (PW),
            .CW (CW)
        ) u_canal (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_aceita    (w_aceita[g]),
            .i_rejeita   (w_rejeita[g]),
            .i_plate     (matricula[g*PW +: PW]),
            .i_veiculo   (veiculo[g]),
            .i_t_aberto  (t_aberto),
            .i_modo      (modo),
            .o_barreira  (barreira[g]),
            .o_aceite    (aceite[g]),
            .o_rejeitada (rejeitada[g]),
            .o_matr_reg  (matr_reg[g*PW +: PW]),
            .o_estado    (w_estado[g])
        );
        assign estado_dbg[g] = w_estado[g];
    end

    // Count the registered accept pulses so simultaneous accepts all count.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            w_pop = w_pop + PCW'(aceite[i]);
        end
    end

    assign w_soma = SW'(r_cont) + SW'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cont <= '0;
        end else if (w_soma[SW-1:CNTW] != '0) begin
            r_cont <= CNT_MAX;
        end else begin
            r_cont <= w_soma[CNTW-1:0];
        end
    end

    assign contagem = r_cont;

endmodule

// File: tb/tb_barreira_ctrl_n.sv
module tb_barreira_ctrl_n;
    import barreira_pkg::*;

    localparam int NCH  = 4;
    localparam int PW   = 24;
    localparam int CW   = 7;
    localparam int CNTW = 16;
    localparam int QW   = 4 + 1 + PW;   // {channel, accepted, plate}

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*PW-1:0] matricula;
    logic [NCH-1:0]    matr_val;
    logic [NCH-1:0]    veiculo;
    logic [CW-1:0]     t_aberto;
    logic [1:0]        modo;
    logic [NCH-1:0]    barreira;
    logic [NCH-1:0]    aceite;
    logic [NCH-1:0]    rejeitada;
    logic [NCH*PW-1:0] matr_reg;
    logic [CNTW-1:0]   contagem;
    logic [NCH-1:0]    estado_dbg;

    barreira_ctrl_n #(
        .NCH  (NCH),
        .PW   (PW),
        .CW   (CW),
        .CNTW (CNTW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .matricula  (matricula),
        .matr_val   (matr_val),
        .veiculo    (veiculo),
        .t_aberto   (t_aberto),
        .modo       (modo),
        .barreira   (barreira),
        .aceite     (aceite),
        .rejeitada  (rejeitada),
        .matr_reg   (matr_reg),
        .contagem   (contagem),
        .estado_dbg (estado_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;
    logic [QW-1:0] exp_q[$];
    logic [QW-1:0] mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: outputs of the edge are visible at the following negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        matr_val = '0;
    endtask

    // Requests within one cycle must be issued in ascending channel order.
    task automatic drive_req(input int ch, input logic [PW-1:0] plate);
        logic acc;
        acc = (plate != '0) && (modo != MODO_FECHAR);
        matr_val[ch] = 1'b1;
        matricula[ch*PW +: PW] = plate;
        exp_q.push_back({4'(ch), acc, plate});
        if (acc && exp_cnt < 65535) exp_cnt++;
    endtask

    // ---------------- monitor: pop and compare every pulse ----------------
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (aceite[c] || rejeitada[c]) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_pulse_ch%0d", c), {30'd0, aceite[c], rejeitada[c]}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_channel", c, {28'd0, mon_e[QW-1 -: 4]});
                    check($sformatf("pulse_kind_ch%0d", c), {30'd0, aceite[c], rejeitada[c]},
                          mon_e[PW] ? 32'd2 : 32'd1);
                    if (mon_e[PW]) begin
                        check($sformatf("matr_reg_ch%0d", c), {8'd0, matr_reg[c*PW +: PW]}, {8'd0, mon_e[PW-1:0]});
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int rem;
        rst_n     = 1'b0;
        matr_val  = '0;
        matricula = '0;
        veiculo   = '0;
        t_aberto  = 7'd5;
        modo      = MODO_AUTO;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_barreira", {28'd0, barreira}, 32'hF);
        check("rst_aceite", {28'd0, aceite}, 32'h0);
        check("rst_rejeitada", {28'd0, rejeitada}, 32'h0);
        check("rst_contagem", {16'd0, contagem}, 32'h0);
        check("rst_matr_reg_or", {31'd0, |matr_reg}, 32'h0);
        check("rst_estado", {28'd0, estado_dbg}, 32'h0);
        rst_n = 1'b1;
        step();

        // Basic open/close on channel 0, t_aberto=5
        drive_req(0, 24'hABC123);
        step();
        check("t1_open", {31'd0, barreira[0]}, 32'd0);
        check("t1_estado", {31'd0, estado_dbg[0]}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("t1_timer_k%0d", k), {31'd0, barreira[0]}, (k == 5) ? 32'd1 : 32'd0);
        end
        check("t1_contagem", {16'd0, contagem}, exp_cnt);

        // Zero plate rejected
        drive_req(1, 24'h000000);
        step();
        check("t2_closed", {31'd0, barreira[1]}, 32'd1);
        step();
        check("t2_contagem", {16'd0, contagem}, exp_cnt);

        // Vehicle holds channel 2 open
        drive_req(2, 24'h123456);
        step();
        step();
        step();
        veiculo[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("t3_held_k%0d", k), {31'd0, barreira[2]}, 32'd0);
        end
        veiculo[2] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("t3_after_k%0d", k), {31'd0, barreira[2]}, (k == 5) ? 32'd1 : 32'd0);
        end

        // Second request at cnt=4 restarts the timer
        drive_req(0, 24'h00BEEF);
        step();
        repeat (4) step();
        check("t4_before", {31'd0, barreira[0]}, 32'd0);
        drive_req(0, 24'h00CAFE);
        step();
        check("t4_restart", {31'd0, barreira[0]}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("t4_timer_k%0d", k), {31'd0, barreira[0]}, (k == 5) ? 32'd1 : 32'd0);
        end
        check("t4_contagem", {16'd0, contagem}, exp_cnt);

        // t_aberto=0 behaves as 1
        t_aberto = 7'd0;
        drive_req(1, 24'h000777);
        step();
        check("t5_open", {31'd0, barreira[1]}, 32'd0);
        step();
        check("t5_closed", {31'd0, barreira[1]}, 32'd1);

        // t_aberto lowered below current count closes next cycle
        t_aberto = 7'd5;
        drive_req(3, 24'h333333);
        step();
        repeat (3) step();
        t_aberto = 7'd2;
        step();
        check("t6_shrink", {31'd0, barreira[3]}, 32'd1);
        t_aberto = 7'd5;

        // Saturation: bring contagem to FFFE, then four simultaneous accepts
        while (exp_cnt + NCH <= 32'hFFFE) begin
            for (int c = 0; c < NCH; c++) drive_req(c, PW'($urandom_range(32'hFFFFFF, 1)));
            step();
        end
        rem = 32'hFFFE - exp_cnt;
        for (int c = 0; c < rem; c++) drive_req(c, PW'($urandom_range(32'hFFFFFF, 1)));
        step();
        repeat (2) step();
        check("t7_fffe", {16'd0, contagem}, 32'hFFFE);
        for (int c = 0; c < NCH; c++) drive_req(c, PW'($urandom_range(32'hFFFFFF, 1)));
        step();
        check("t7_all_aceite", {28'd0, aceite}, 32'hF);
        step();
        check("t7_ffff", {16'd0, contagem}, 32'hFFFF);
        drive_req(0, 24'h0000AA);
        step();
        step();
        check("t7_hold_sat", {16'd0, contagem}, exp_cnt);
        repeat (6) step();
        check("t7_all_closed", {28'd0, barreira}, 32'hF);

        // Force-closed never lowers onto a vehicle
        t_aberto = 7'd20;
        drive_req(3, 24'h0A0A0A);
        step();
        veiculo[3] = 1'b1;
        step();
        modo = MODO_FECHAR;
        drive_req(0, 24'h111111);
        step();
        check("t8_held", {31'd0, barreira[3]}, 32'd0);
        check("t8_ch0_closed", {31'd0, barreira[0]}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t8_held_k%0d", k), {31'd0, barreira[3]}, 32'd0);
        end
        veiculo[3] = 1'b0;
        step();
        check("t8_closed", {31'd0, barreira[3]}, 32'd1);

        // Force-open, then back to auto restarts the timer
        modo = MODO_ABRIR;
        step();
        check("t9_all_open", {28'd0, barreira}, 32'h0);
        drive_req(2, 24'h222222);
        step();
        check("t9_still_open", {28'd0, barreira}, 32'h0);
        t_aberto = 7'd3;
        modo = MODO_AUTO;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("t9_auto_k%0d", k), {28'd0, barreira}, (k == 3) ? 32'hF : 32'h0);
        end

        // Asynchronous reset mid-open, vehicle present
        modo = MODO_ABRIR;
        veiculo = 4'h1;
        step();
        check("t10_open", {28'd0, barreira}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("t10_rst_barreira", {28'd0, barreira}, 32'hF);
        check("t10_rst_contagem", {16'd0, contagem}, 32'h0);
        check("t10_rst_matr_reg_or", {31'd0, |matr_reg}, 32'h0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        modo = MODO_AUTO;
        veiculo = '0;
        step();
        check("t10_after", {28'd0, barreira}, 32'hF);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
